// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the 68000 bus arbiter.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    CPU_OWN  = 3'd0,
    WAIT_CYC = 3'd1,
    GRANT    = 3'd2,
    DMA_OWN  = 3'd3,
    RELEASE  = 3'd4
  } arb_state_t;

  localparam logic [3:0] OWNER_CPU = 4'd0;
  localparam int         MAX_REQ   = 8;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping at NREQ.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end else begin
      sum = sum;
    end
    return IDX_W'(sum);
  endfunction

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    idx   = {IDX_W{1'b0}};
    valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        idx   = wrap_add(ptr, k);
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// 68000 bus arbiter: CPU vs NREQ DMA channels, round-robin with a CPU hold-off slot.
// Optional bus-timeout watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int CPU_SLOT = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_as_n,
  input  logic            bus_as_n,
  input  logic            bus_dtack_n,
  input  logic [NREQ-1:0] dma_req,
  input  logic [NREQ-1:0] dma_done,
  output logic [NREQ-1:0] dma_grant,
  output logic            dma_active_n,
  output logic [3:0]      bus_owner,
  output logic            buserr
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SLOT_W = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(CPU_SLOT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NREQ - 1);

  arb_state_t        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              active_n_q, active_n_d;
  logic [3:0]        owner_q, owner_d;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_valid_s;

  rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req   (dma_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Next-state and registered-output logic for the ownership FSM.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    rr_ptr_d   = rr_ptr_q;
    winner_d   = winner_q;
    grant_d    = grant_q;
    active_n_d = active_n_q;
    owner_d    = owner_q;
    case (state_q)
      CPU_OWN: begin
        if (slot_q != SLOT_MAX) begin
          slot_d = slot_q + SLOT_W'(1);
        end else begin
          slot_d = slot_q;
        end
        if ((slot_q == SLOT_MAX) && (|dma_req)) begin
          state_d = cpu_as_n ? GRANT : WAIT_CYC;
        end else begin
          state_d = CPU_OWN;
        end
      end
      WAIT_CYC: begin
        if (!(|dma_req)) begin
          state_d = CPU_OWN;
        end else if (cpu_as_n) begin
          state_d = GRANT;
        end else begin
          state_d = WAIT_CYC;
        end
      end
      GRANT: begin
        // Requests may have vanished since arming; fall back without a grant.
        if (pick_valid_s) begin
          state_d    = DMA_OWN;
          winner_d   = pick_idx_s;
          grant_d    = NREQ'(onehot(3'(pick_idx_s)));
          active_n_d = 1'b0;
          owner_d    = 4'(pick_idx_s) + 4'd1;
        end else begin
          state_d = CPU_OWN;
        end
      end
      DMA_OWN: begin
        if (dma_req[winner_q] && !dma_done[winner_q]) begin
          state_d = DMA_OWN;
        end else begin
          state_d  = RELEASE;
          grant_d  = {NREQ{1'b0}};
          rr_ptr_d = (winner_q == LAST_IDX) ? {IDX_W{1'b0}} : winner_q + IDX_W'(1);
        end
      end
      RELEASE: begin
        state_d    = CPU_OWN;
        active_n_d = 1'b1;
        owner_d    = OWNER_CPU;
        slot_d     = {SLOT_W{1'b0}};
      end
      default: begin
        state_d    = CPU_OWN;
        grant_d    = {NREQ{1'b0}};
        active_n_d = 1'b1;
        owner_d    = OWNER_CPU;
      end
    endcase
  end

  // State and output registers; reset leaves the slot satisfied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CPU_OWN;
      slot_q     <= SLOT_MAX;
      rr_ptr_q   <= {IDX_W{1'b0}};
      winner_q   <= {IDX_W{1'b0}};
      grant_q    <= {NREQ{1'b0}};
      active_n_q <= 1'b1;
      owner_q    <= OWNER_CPU;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      rr_ptr_q   <= rr_ptr_d;
      winner_q   <= winner_d;
      grant_q    <= grant_d;
      active_n_q <= active_n_d;
      owner_q    <= owner_d;
    end
  end

  assign dma_grant    = grant_q;
  assign dma_active_n = active_n_q;
  assign bus_owner    = owner_q;

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        wd_fired_q, wd_fired_d;
  logic        buserr_q, buserr_d;

  // Watchdog: one pulse per stalled strobe, re-armed only by strobe release or dtack.
  always_comb begin
    wd_cnt_d   = wd_cnt_q;
    wd_fired_d = wd_fired_q;
    buserr_d   = 1'b0;
    if (bus_as_n || !bus_dtack_n) begin
      wd_cnt_d   = 16'd0;
      wd_fired_d = 1'b0;
    end else if (wd_fired_q) begin
      wd_cnt_d = wd_cnt_q;
    end else if (wd_cnt_q == WD_LAST) begin
      buserr_d   = 1'b1;
      wd_fired_d = 1'b1;
    end else begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q   <= 16'd0;
      wd_fired_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      wd_fired_q <= wd_fired_d;
      buserr_q   <= buserr_d;
    end
  end

  assign buserr = buserr_q;
`else
  logic unused_wd_s;
  assign unused_wd_s = bus_as_n ^ bus_dtack_n ^ (TIMEOUT == 0);
  assign buserr      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized phase
// checked against a rule-level round-robin model. Define BUS_TIMEOUT_EN to cover the watchdog.
module tb_bus_arbiter;

  localparam int NREQ     = 3;
  localparam int CPU_SLOT = 4;
  localparam int TIMEOUT  = 16;

  logic            clk = 1'b0;
  logic            reset, cpu_as_n, bus_as_n, bus_dtack_n;
  logic [NREQ-1:0] dma_req, dma_done, dma_grant;
  logic            dma_active_n, buserr;
  logic [3:0]      bus_owner;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NREQ(NREQ), .CPU_SLOT(CPU_SLOT), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_as_n     (cpu_as_n),
    .bus_as_n     (bus_as_n),
    .bus_dtack_n  (bus_dtack_n),
    .dma_req      (dma_req),
    .dma_done     (dma_done),
    .dma_grant    (dma_grant),
    .dma_active_n (dma_active_n),
    .bus_owner    (bus_owner),
    .buserr       (buserr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: first requesting channel at or after ptr, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] oh(input int c);
    logic [31:0] one;
    one = 32'd1;
    return (c < 0) ? 32'd0 : (one << c);
  endfunction

  int              waited, hi, exp_ch, m_w, m_ptr;
  bit              seen, m_turn, stay;
  logic [NREQ-1:0] prev_req, prev_done;
  logic            cpu_e0, cpu_e1;

  initial begin
    reset = 1'b1; cpu_as_n = 1'b1; bus_as_n = 1'b1; bus_dtack_n = 1'b1;
    dma_req = '0; dma_done = '0;
    step(); step();
    chk("rst_grant", dma_grant, 0);
    chk("rst_active_n", dma_active_n, 1);
    chk("rst_owner", bus_owner, 0);
    chk("rst_buserr", buserr, 0);

    // 1: idle CPU, slot satisfied after reset -> grant on 2nd edge
    reset = 1'b0; dma_req = 3'b001;
    step(); chk("t1_edge1_grant", dma_grant, 0);
    step();
    chk("t1_grant", dma_grant, 3'b001);
    chk("t1_active_n", dma_active_n, 0);
    chk("t1_owner", bus_owner, 1);
    dma_req = 3'b000;
    step();
    chk("t1_rel_grant", dma_grant, 0);
    chk("t1_rel_active_n", dma_active_n, 0);
    step();
    chk("t1_cpu_active_n", dma_active_n, 1);
    chk("t1_cpu_owner", bus_owner, 0);

    // 2: CPU mid-cycle holds off the grant
    cpu_as_n = 1'b0; dma_req = 3'b010;
    for (int i = 0; i < 8; i++) begin
      step(); chk("t2_stall_grant", dma_grant, 0);
    end
    cpu_as_n = 1'b1;
    step(); chk("t2_edge1_grant", dma_grant, 0);
    step();
    chk("t2_grant", dma_grant, 3'b010);
    chk("t2_owner", bus_owner, 2);
    dma_done = 3'b010;
    step();
    dma_done = 3'b000; dma_req = 3'b000;
    chk("t2_rel_grant", dma_grant, 0);
    chk("t2_rel_active_n", dma_active_n, 0);
    step(); chk("t2_cpu_active_n", dma_active_n, 1);

    // 3: round robin with all channels requesting
    reset = 1'b1; step(); reset = 1'b0;
    dma_req = 3'b111; hi = 0;
    for (int t = 0; t < 4; t++) begin
      exp_ch = t % NREQ;
      waited = 0;
      while (dma_grant == '0 && waited < 20) begin
        step();
        if (dma_active_n) hi++;
        waited++;
      end
      chk("t3_grant_wait", (waited < 20), 1);
      chk("t3_order", dma_grant, oh(exp_ch));
      if (t > 0) chk("t3_cpu_slot", (hi >= CPU_SLOT), 1);
      step(); step();
      chk("t3_hold", dma_grant, oh(exp_ch));
      dma_done = NREQ'(oh(exp_ch));
      step();
      dma_done = '0;
      if (t == 3) dma_req = 3'b000;
      chk("t3_rel_grant", dma_grant, 0);
      chk("t3_rel_active_n", dma_active_n, 0);
      step();
      chk("t3_cpu_active_n", dma_active_n, 1);
      hi = 1;
    end

    // 4: request vanishes while waiting for the CPU
    for (int i = 0; i < 6; i++) step();
    cpu_as_n = 1'b0; dma_req = 3'b100;
    step(); step();
    chk("t4_wait_grant", dma_grant, 0);
    dma_req = 3'b000;
    step();
    cpu_as_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_grant", dma_grant, 0);
      chk("t4_active_n", dma_active_n, 1);
    end

    // 5: reset during a tenancy
    dma_req = 3'b001;
    waited = 0;
    while (dma_grant == '0 && waited < 10) begin
      step(); waited++;
    end
    chk("t5_grant", dma_grant, 3'b001);
    reset = 1'b1;
    step();
    chk("t5_rst_grant", dma_grant, 0);
    chk("t5_rst_active_n", dma_active_n, 1);
    chk("t5_rst_owner", bus_owner, 0);
    reset = 1'b0; dma_req = 3'b000;
    step();

    // 6: bus timeout watchdog
    bus_as_n = 1'b0; bus_dtack_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
`ifdef BUS_TIMEOUT_EN
      chk("t6_buserr", buserr, (i == 16));
`else
      chk("t6_buserr_off", buserr, 0);
`endif
    end
    bus_as_n = 1'b1;
    step(); chk("t6_buserr_idle", buserr, 0);

    // Randomized traffic against the rule model
    reset = 1'b1; dma_req = '0; dma_done = '0; cpu_as_n = 1'b1;
    step(); reset = 1'b0;
    m_w = -1; m_ptr = 0; hi = 0; seen = 1'b0; m_turn = 1'b0;
    cpu_e0 = cpu_as_n;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 7) == 0) dma_req[b] = ~dma_req[b];
        dma_done[b] = ($urandom_range(0, 5) == 0);
      end
      cpu_as_n  = ($urandom_range(0, 3) != 0);
      prev_req  = dma_req;
      prev_done = dma_done;
      cpu_e1    = cpu_e0;
      cpu_e0    = cpu_as_n;
      step();
      chk("rnd_onehot", $onehot0(dma_grant), 1);
      if (dma_grant != '0) chk("rnd_active_w_grant", dma_active_n, 0);
      else if (dma_active_n) chk("rnd_owner_cpu", bus_owner, 0);
      if (m_turn) begin
        chk("rnd_turn_end", dma_active_n, 1);
        m_turn = 1'b0;
      end
      if (m_w < 0 && dma_grant != '0) begin
        exp_ch = rr_pick(prev_req, m_ptr);
        chk("rnd_winner", dma_grant, oh(exp_ch));
        chk("rnd_owner", bus_owner, exp_ch + 1);
        chk("rnd_cpu_idle", cpu_e1, 1);
        if (seen) chk("rnd_cpu_slot", (hi >= CPU_SLOT), 1);
        m_w = exp_ch;
      end else if (m_w >= 0) begin
        stay = prev_req[m_w] && !prev_done[m_w];
        chk("rnd_hold_release", dma_grant, stay ? oh(m_w) : 32'd0);
        if (!stay) begin
          chk("rnd_turnaround", dma_active_n, 0);
          m_ptr  = (m_w + 1) % NREQ;
          m_w    = -1;
          seen   = 1'b1;
          hi     = 0;
          m_turn = 1'b1;
        end
      end
      if (dma_active_n) hi++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
